// File: rtl/bla_subtractor_seq.sv
// rtl/bla_subtractor_seq.sv - 16-bit nibble-serial subtractor (a - b - bin); optional ovf output under SUB_OVF_FLAG_EN
module bla_subtractor_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] d,
    output logic        bout,
    output logic        zero
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  k_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        borrow_q;
    logic [15:0] d_q;
    logic        bout_q;
    logic        zero_q;
    logic        in_ready_q;
    logic        out_valid_q;
`ifdef SUB_OVF_FLAG_EN
    logic        ovf_q;
`endif

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  p;
    logic [3:0]  g;
    logic [4:0]  c;
    logic [3:0]  nib_d;
    logic [15:0] d_d;
    logic        borrow_d;

    // One 4-bit lookahead stage computing a + ~b + ~borrow on nibble k.
    always_comb begin
        nib_a = a_q[{k_q[1:0], 2'b00} +: 4];
        nib_b = b_q[{k_q[1:0], 2'b00} +: 4];
        p     = nib_a ^ ~nib_b;
        g     = nib_a & ~nib_b;
        c[0]  = ~borrow_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib_d = p ^ c[3:0];
        borrow_d = ~c[4];
        d_d = d_q;
        d_d[{k_q[1:0], 2'b00} +: 4] = nib_d;
    end

    // k = 0..3 process nibbles; k = 4 is the finalize step that publishes the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= 3'd0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            borrow_q    <= 1'b0;
            d_q         <= 16'h0000;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        borrow_q   <= bin;
                        k_q        <= 3'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (k_q == 3'd4) begin
                        bout_q      <= borrow_q;
                        zero_q      <= (d_q == 16'h0000);
`ifdef SUB_OVF_FLAG_EN
                        ovf_q       <= (a_q[15] != b_q[15]) && (d_q[15] != a_q[15]);
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        d_q      <= d_d;
                        borrow_q <= borrow_d;
                        k_q      <= k_q + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
`ifdef SUB_OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule
